crack_sched: RTL

- Multi-core key-space scheduler for the ARC4 cracking datapath.
- Takes one inclusive 24-bit search range and splits it into fixed-size chunks.
- Dispatches each chunk to one of NUM_CORES `crack` engines through their en/rdy/low_key/high_key interface.
- Collects key_valid/key, aborts remaining cores on the first hit, and reports one result upstream.

---
 rtl/crack_pkg.sv | 30 +++
 rtl/crack_sched_if.sv | 33 +++
 rtl/crack_prio_enc.sv | 23 ++
 rtl/crack_sched.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and helpers for the ARC4 key-space scheduler.
package crack_pkg;

    localparam int unsigned KEY_W = 24;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [KEY_W:0]   keyptr_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ABORT,
        FINISH
    } sched_state_e;

    localparam key_t KEY_MAX = 24'hFFFFFF;

    // Last key of the chunk starting at ptr, clipped to the range end.
    function automatic key_t chunk_last(input keyptr_t ptr, input key_t chunk, input key_t hi);
        keyptr_t last;
        last = ptr + keyptr_t'(chunk) - keyptr_t'(1);
        return (last > keyptr_t'(hi)) ? hi : key_t'(last);
    endfunction

    // No keys left once the pointer passes the range end or wraps past KEY_MAX.
    function automatic logic ptr_exhausted(input keyptr_t ptr, input key_t hi);
        return (ptr > keyptr_t'(hi)) || (ptr > keyptr_t'(KEY_MAX));
    endfunction

endpackage

// File: rtl/crack_sched_if.sv
// Upstream request/result handshake plus the per-core engine bus.
interface crack_sched_if #(
    parameter int unsigned NUM_CORES = 2
);
    import crack_pkg::*;

    logic                     en;
    logic                     rdy;
    key_t                     low_key;
    key_t                     high_key;
    key_t                     key;
    logic                     key_valid;
    logic [NUM_CORES-1:0]     core_en;
    logic [NUM_CORES-1:0]     core_rdy;
    logic [24*NUM_CORES-1:0]  core_low_key;
    logic [24*NUM_CORES-1:0]  core_high_key;
    logic [24*NUM_CORES-1:0]  core_key;
    logic [NUM_CORES-1:0]     core_key_valid;
    logic [NUM_CORES-1:0]     core_abort;

    // Environment side: issues requests and hosts the crack engines.
    modport master (
        output en, low_key, high_key, core_rdy, core_key, core_key_valid,
        input  rdy, key, key_valid, core_en, core_low_key, core_high_key, core_abort
    );

    // Scheduler side.
    modport slave (
        input  en, low_key, high_key, core_rdy, core_key, core_key_valid,
        output rdy, key, key_valid, core_en, core_low_key, core_high_key, core_abort
    );

endinterface

// File: rtl/crack_prio_enc.sv
// Lowest-set-bit priority encoder with an any-request flag.
module crack_prio_enc #(
    parameter  int unsigned W  = 2,
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    // Scan from the top so the lowest set bit is written last and wins.
    always_comb begin
        idx_c = '0;
        any_c = 1'b0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c = IW'(i);
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crack_sched.sv
// Splits one inclusive key range into chunks, farms them out to the crack
// engines, and stops everything on the first reported key.
module crack_sched
    import crack_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2,
    parameter key_t        CHUNK     = 24'h000100
) (
    input  logic          clk,
    input  logic          rst,
    crack_sched_if.slave  bus
);

    localparam int unsigned KW = KEY_W;
    localparam int unsigned IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned BW = KW * NUM_CORES;

    sched_state_e state, next_state;

    keyptr_t              next_ptr_q, next_ptr_d;
    key_t                 high_q, high_d;
    logic [NUM_CORES-1:0] busy_q, busy_d;
    logic [NUM_CORES-1:0] started_q, started_d;

    logic                 rdy_q, rdy_d;
    key_t                 key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic [NUM_CORES-1:0] core_en_q, core_en_d;
    logic [NUM_CORES-1:0] core_abort_q, core_abort_d;
    logic [BW-1:0]        low_keys_q, low_keys_d;
    logic [BW-1:0]        high_keys_q, high_keys_d;

    logic [NUM_CORES-1:0] avail_c;
    logic [NUM_CORES-1:0] done_c;
    logic [NUM_CORES-1:0] hit_c;
    logic [IW-1:0]        disp_idx_c, hit_idx_c;
    logic                 disp_any_c, hit_any_c;
    logic                 exhausted_c;

    // Only cores we handed work to count; a completion needs rdy to have dropped first.
    assign avail_c     = ~busy_q & bus.core_rdy;
    assign done_c      = busy_q & started_q & bus.core_rdy;
    assign hit_c       = done_c & bus.core_key_valid;
    assign exhausted_c = ptr_exhausted(next_ptr_q, high_q);

    crack_prio_enc #(.W(NUM_CORES)) u_disp_enc (
        .req   (avail_c),
        .idx_c (disp_idx_c),
        .any_c (disp_any_c)
    );

    crack_prio_enc #(.W(NUM_CORES)) u_hit_enc (
        .req   (hit_c),
        .idx_c (hit_idx_c),
        .any_c (hit_any_c)
    );

    // Next-state, bookkeeping and registered-output values.
    always_comb begin
        next_state   = state;
        next_ptr_d   = next_ptr_q;
        high_d       = high_q;
        busy_d       = busy_q;
        started_d    = started_q;
        key_d        = key_q;
        key_valid_d  = key_valid_q;
        core_en_d    = '0;
        core_abort_d = '0;
        low_keys_d   = low_keys_q;
        high_keys_d  = high_keys_q;

        case (state)
            IDLE: begin
                if (bus.en) begin
                    high_d      = bus.high_key;
                    next_ptr_d  = keyptr_t'(bus.low_key);
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    next_state  = (bus.low_key > bus.high_key) ? FINISH : RUN;
                end
            end
            RUN: begin
                started_d = (started_q | (busy_q & ~bus.core_rdy)) & ~done_c;
                busy_d    = busy_q & ~done_c;
                if (hit_any_c) begin
                    key_d        = bus.core_key[32'(hit_idx_c) * KW +: KW];
                    key_valid_d  = 1'b1;
                    core_abort_d = busy_d;
                    next_state   = ABORT;
                end else if (disp_any_c && !exhausted_c) begin
                    core_en_d[disp_idx_c] = 1'b1;
                    busy_d[disp_idx_c]    = 1'b1;
                    low_keys_d[32'(disp_idx_c) * KW +: KW]  = key_t'(next_ptr_q);
                    high_keys_d[32'(disp_idx_c) * KW +: KW] = chunk_last(next_ptr_q, CHUNK, high_q);
                    next_ptr_d = next_ptr_q + keyptr_t'(CHUNK);
                end else if (exhausted_c && (busy_d == '0)) begin
                    next_state = FINISH;
                end
            end
            ABORT: begin
                busy_d     = '0;
                started_d  = '0;
                next_state = FINISH;
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        rdy_d = (next_state == IDLE);
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            next_ptr_q   <= '0;
            high_q       <= '0;
            busy_q       <= '0;
            started_q    <= '0;
            rdy_q        <= 1'b1;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            core_en_q    <= '0;
            core_abort_q <= '0;
            low_keys_q   <= '0;
            high_keys_q  <= '0;
        end else begin
            state        <= next_state;
            next_ptr_q   <= next_ptr_d;
            high_q       <= high_d;
            busy_q       <= busy_d;
            started_q    <= started_d;
            rdy_q        <= rdy_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            core_en_q    <= core_en_d;
            core_abort_q <= core_abort_d;
            low_keys_q   <= low_keys_d;
            high_keys_q  <= high_keys_d;
        end
    end

    assign bus.rdy           = rdy_q;
    assign bus.key           = key_q;
    assign bus.key_valid     = key_valid_q;
    assign bus.core_en       = core_en_q;
    assign bus.core_abort    = core_abort_q;
    assign bus.core_low_key  = low_keys_q;
    assign bus.core_high_key = high_keys_q;

endmodule
